// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle shift-and-add multiplier that borrows the shared
// combinational ALU for one add per iteration. It produces the low DWIDTH bits
// of in_a * in_b. That value is the same for signed and unsigned operands.
// Operands come in on a valid/ready port. The product is held on a
// valid/ready port until it is consumed.
module alu_mul_seq #(
   parameter int                     DWIDTH      = 32,
   parameter int                     ALUOP_WIDTH = 4,
   // ALU operation codes; override to match the datapath's ALU encoding
   parameter logic [ALUOP_WIDTH-1:0] ALU_ADD     = 4'h0,
   parameter logic [ALUOP_WIDTH-1:0] ALU_A       = 4'hA
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DWIDTH-1:0]      in_a,
   input  logic [DWIDTH-1:0]      in_b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DWIDTH-1:0]      result,
   output logic                   busy,
   output logic [DWIDTH-1:0]      alu_a,
   output logic [DWIDTH-1:0]      alu_b,
   output logic [ALUOP_WIDTH-1:0] alu_op,
   input  logic [DWIDTH-1:0]      alu_y
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [DWIDTH-1:0] acc, acc_next;
   logic [DWIDTH-1:0] mcand, mcand_next;
   logic [DWIDTH-1:0] mplier, mplier_next;
   logic [DWIDTH-1:0] mplier_shr;

   // Remaining multiplier bits after this iteration. Zero means the last
   // set bit has just been consumed, so no further adds can change acc.
   assign mplier_shr = mplier >> 1;

   // All handshake and ownership outputs decode registered state only, so none
   // of them combinationally depends on in_valid, out_ready or flush.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN);
   assign result    = acc;

   // Register the FSM state; asynchronous reset returns to IDLE at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Register the datapath; a reset mid-operation clears any partial product
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else begin
         acc    <= acc_next;
         mcand  <= mcand_next;
         mplier <= mplier_next;
      end
   end

   // Drive the ALU from state alone: add acc + mcand while RUN, pass-through of
   // zero otherwise, so the external mux sees a quiet ALU when busy is low
   always_comb begin
      alu_a  = '0;
      alu_b  = '0;
      alu_op = ALU_A;
      if (state == RUN) begin
         alu_a  = acc;
         alu_b  = mcand;
         alu_op = ALU_ADD;
      end
   end

   // Next-state and datapath update; flush overrides every other input
   always_comb begin
      state_next  = state;
      acc_next    = acc;
      mcand_next  = mcand;
      mplier_next = mplier;

      if (flush) begin
         // Drop whatever is in flight or held, including a same-cycle request
         state_next  = IDLE;
         acc_next    = '0;
         mcand_next  = '0;
         mplier_next = '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  acc_next    = '0;
                  mcand_next  = in_a;
                  mplier_next = in_b;
                  state_next  = RUN;
               end
            end

            RUN: begin
               // One multiplier bit per cycle; the adder output wraps mod 2^DWIDTH
               if (mplier[0]) begin
                  acc_next = alu_y;
               end
               mcand_next  = mcand << 1;
               mplier_next = mplier_shr;
               // A zero multiplier still spends one RUN cycle, with no add
               if (mplier_shr == '0) begin
                  state_next = DONE;
               end
            end

            DONE: begin
               // acc is held so result stays stable until the consumer takes it
               if (out_ready) begin
                  state_next = IDLE;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Multi-cycle multiply sequencer that drives the shared combinational `alu` to compute the low DWIDTH bits of `a * b` by shift-and-add. Operands enter through a valid/ready handshake. Each iteration uses the ALU for one add, and the result is held on a valid/ready output port until consumed. It sits beside the execute stage and owns the ALU operand and op inputs while busy. An external mux hands the ALU back to the datapath whenever `busy` is low.

## Interface
- `DWIDTH`, default 32: operand, result and ALU data width.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `flush` input 1: synchronous abort; drops any in-flight or held operation.
- `in_valid` input 1: operands `in_a`/`in_b` are valid.
- `in_ready` output 1: sequencer can accept operands.
- `in_a` input DWIDTH: multiplicand.
- `in_b` input DWIDTH: multiplier.
- `out_valid` output 1: `result` holds a completed product.
- `out_ready` input 1: consumer accepts `result`.
- `result` output DWIDTH: product, mod 2^DWIDTH.
- `busy` output 1: sequencer owns the ALU (state RUN).
- `alu_a` output DWIDTH: ALU operand a.
- `alu_b` output DWIDTH: ALU operand b.
- `alu_op` output `ALUOP_WIDTH`: ALU operation, encoded per `alu_ops.vh`.
- `alu_y` input DWIDTH: ALU result, combinational from `alu_a`/`alu_b`/`alu_op`.

## Operation
- Registers:
  - `acc` (DWIDTH), drives `result`.
  - `mcand` (DWIDTH).
  - `mplier` (DWIDTH).
  - `state`, one of IDLE, RUN, DONE.
- Reset values:
  - state = IDLE.
  - `acc`, `mcand`, `mplier` = 0.
  - Outputs: `in_ready` = 1, `out_valid` = 0, `busy` = 0, `result` = 0.
- Output decode:
  - `in_ready` = (state == IDLE).
  - `out_valid` = (state == DONE).
  - `busy` = (state == RUN).
- IDLE:
  - On `in_valid & in_ready`: `acc` <= 0, `mcand` <= `in_a`, `mplier` <= `in_b`, state <= RUN.
  - ALU drive: `alu_a` = 0, `alu_b` = 0, `alu_op` = `ALU_A`.
- RUN, one iteration per cycle:
  - ALU drive: `alu_a` = `acc`, `alu_b` = `mcand`, `alu_op` = `ALU_ADD`.
  - If `mplier[0]`: `acc` <= `alu_y`; otherwise `acc` holds.
  - `mcand` <= `mcand` << 1 (bits shifted out are lost).
  - `mplier` <= `mplier` >> 1 (logical shift).
  - If (`mplier` >> 1) == 0: state <= DONE.
- DONE:
  - ALU drive: same as IDLE.
  - `result` = `acc`, held stable until the handshake.
  - On `out_valid & out_ready`: state <= IDLE.
  - `in_valid` is ignored (`in_ready` = 0).
- Arithmetic:
  - All adds wrap mod 2^DWIDTH.
  - The result equals the low half of both the signed and the unsigned product, so no sign handling is needed.
- `flush`:
  - Overrides all other inputs.
  - Next state is IDLE from any state; `acc`, `mcand`, `mplier` <= 0.
  - An `in_valid` in the same cycle is not accepted.
  - A held result is discarded.
- Reset mid-operation: everything returns to reset values immediately; no partial result is ever presented.

## Timing
- Let k = max(1, msb_index(`in_b`) + 1), so 1 <= k <= DWIDTH.
- Operands are accepted at edge E0.
- State is RUN for k cycles and DONE after edge E0+k.
- `out_valid` first asserts in the cycle following edge E0+k.
- `in_b` = 0 gives k = 1: one RUN cycle with no add, then DONE with `result` = 0.
- Throughput: after the output handshake edge, one IDLE cycle follows before the next acceptance. There is no operand acceptance while RUN or DONE.
- The ALU path is combinational within one cycle. `alu_y` must settle from `alu_a`/`alu_b`/`alu_op` in the same cycle; there is no extra register stage.
- All outputs are registered-state decodes. None depends combinationally on `in_valid` or `out_ready`.

## Test plan
- Small product:
  - Stimulus: `in_a` = 3, `in_b` = 5.
  - Required: `result` = 15; `out_valid` asserts after 3 RUN cycles; `busy` is high exactly 3 cycles.
- Wrap-around, full length:
  - Stimulus: `in_a` = `in_b` = 0xFFFFFFFF.
  - Required: `result` = 0x00000001 after 32 RUN cycles.
- Zero multiplier:
  - Stimulus: `in_a` = 0x1234, `in_b` = 0.
  - Required: `result` = 0 after 1 RUN cycle.
  - Also: `alu_op` = `ALU_ADD` only during that cycle, `ALU_A` otherwise.
- Back-pressure in DONE:
  - Stimulus: `out_ready` held low 5 cycles during DONE, with `in_valid` pulsed.
  - Required: `result` stable, `in_ready` = 0, operands not accepted.
  - After `out_ready` rises: IDLE, then the next operation is accepted one cycle later.
- Abort during RUN:
  - Stimulus: `flush` in RUN cycle 10 of 0xFFFFFFFF * 0xFFFFFFFF; in a separate run, `rst` asserted mid-cycle.
  - Required: IDLE next, `out_valid` never asserted, `result` = 0.
  - Required: a following 7 * 6 yields 42.
- Random regression:
  - Stimulus: 1000 random operand pairs with random `out_ready` stalls.
  - Required: every `result` = (`in_a` * `in_b`) mod 2^32, and each latency equals k.
